obuf_arb: RTL and testbench



---
 rtl/obuf_arb_pkg.sv | 18 +
 rtl/obuf_arb_rr.sv | 41 ++++
 rtl/obuf_arb.sv | 99 +++++++++
 tb/tb_obuf_arb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/obuf_arb_pkg.sv
// Shared constants for the router output stage: payload width, port count
// and the direction indices used to number the requesting input buffers.
package obuf_arb_pkg;

  localparam int PKT_W  = 32;
  localparam int N_PORT = 7;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_S = 3'd1,
    DIR_E = 3'd2,
    DIR_W = 3'd3,
    DIR_B = 3'd4,
    DIR_Q = 3'd5,
    DIR_R = 3'd6
  } dir_e;

endpackage

// File: rtl/obuf_arb_rr.sv
// Combinational round-robin arbiter (module rr_arb): searches a doubled request
// vector starting one past the last served index, giving one-hot and encoded grants.
module rr_arb #(
  parameter int N_IN  = 7,
  parameter int IDX_W = 3
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_IN-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [2*N_IN-1:0] dbl;
  int                start;
  int                idx;
  logic              found;

  // Bits below the start position are masked in the low copy; the high copy
  // catches the wrapped-around requesters so a single lowest-set search suffices.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    start   = (int'(ptr) >= N_IN - 1) ? 0 : int'(ptr) + 1;
    for (int j = 0; j < 2 * N_IN; j++) begin
      dbl[j] = (j >= start) ? req[j % N_IN] : 1'b0;
    end
    for (int j = 0; j < 2 * N_IN; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        idx   = (j >= N_IN) ? j - N_IN : j;
      end
    end
    if (found) begin
      gnt[idx] = 1'b1;
      gnt_idx  = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/obuf_arb.sv
// Output-direction arbiter plus small FIFO toward the link.
// Optional packet statistics counter enabled with macro OBUF_STAT_EN.
module obuf_arb
  import obuf_arb_pkg::*;
#(
  parameter int PYLD_W = PKT_W,
  parameter int N_IN   = N_PORT,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        arb_req,
  input  logic [N_IN*PYLD_W-1:0] payload_i,
  output logic [N_IN-1:0]        arb_gnt,
  output logic                   obuf_rdy,
  output logic                   obuf_vld,
  input  logic                   link_rdy,
  output logic [PYLD_W-1:0]      payload_o,
  output logic [15:0]            pkt_cnt
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]  ptr_q, ptr_d, gnt_idx;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PYLD_W-1:0] mem_q [DEPTH];
  logic [PYLD_W-1:0] sel_pyld;
  logic              push, pop;

  rr_arb #(.N_IN(N_IN), .IDX_W(IDX_W)) u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx)
  );

  // Ready/valid come from the occupancy register only, so no comb path from link_rdy.
  assign obuf_rdy  = (cnt_q != CW'(DEPTH));
  assign obuf_vld  = (cnt_q != '0);
  assign push      = (|arb_gnt) & obuf_rdy;
  assign pop       = obuf_vld & link_rdy;
  assign sel_pyld  = payload_i[int'(gnt_idx)*PYLD_W +: PYLD_W];
  assign payload_o = mem_q[rd_q];

  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = gnt_idx;
      wr_d  = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer resets to the last index so input 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(N_IN - 1);
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= sel_pyld;
  end

`ifdef OBUF_STAT_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst)                            stat_q <= '0;
    else if (push && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
  end

  assign pkt_cnt = stat_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_obuf_arb.sv
// Directed table-driven bench for obuf_arb: grant order, FIFO data order,
// backpressure, mid-operation reset and the optional packet counter.
module tb_obuf_arb;

  localparam int N_IN   = 7;
  localparam int PYLD_W = 8;
  localparam int DEPTH  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_IN-1:0]        arb_req;
  logic [N_IN*PYLD_W-1:0] payload_i;
  logic [N_IN-1:0]        arb_gnt;
  logic                   obuf_rdy;
  logic                   obuf_vld;
  logic                   link_rdy;
  logic [PYLD_W-1:0]      payload_o;
  logic [15:0]            pkt_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] req;
    logic       link;
    logic [6:0] gnt;
    logic       rdy;
    logic       vld;
    logic [7:0] pay;
    logic       chkp;
  } vec_t;

  vec_t vecs[$];

  obuf_arb #(.PYLD_W(PYLD_W), .N_IN(N_IN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_req   (arb_req),
    .payload_i (payload_i),
    .arb_gnt   (arb_gnt),
    .obuf_rdy  (obuf_rdy),
    .obuf_vld  (obuf_vld),
    .link_rdy  (link_rdy),
    .payload_o (payload_o),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [6:0] r, input logic l);
    arb_req  = r;
    link_rdy = l;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Input i always presents 0xA0+i so FIFO output identifies the source.
  initial begin
    for (int i = 0; i < N_IN; i++) payload_i[i*PYLD_W +: PYLD_W] = 8'hA0 + 8'(i);

    // Round-robin with simultaneous push/pop at occupancy 1, then drain.
    vecs.push_back('{7'h7F, 1'b1, 7'h01, 1'b1, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{7'h7F, 1'b1, 7'h02, 1'b1, 1'b1, 8'hA0, 1'b1});
    vecs.push_back('{7'h7F, 1'b1, 7'h04, 1'b1, 1'b1, 8'hA1, 1'b1});
    vecs.push_back('{7'h7F, 1'b1, 7'h08, 1'b1, 1'b1, 8'hA2, 1'b1});
    vecs.push_back('{7'h7F, 1'b1, 7'h10, 1'b1, 1'b1, 8'hA3, 1'b1});
    vecs.push_back('{7'h7F, 1'b1, 7'h20, 1'b1, 1'b1, 8'hA4, 1'b1});
    vecs.push_back('{7'h7F, 1'b1, 7'h40, 1'b1, 1'b1, 8'hA5, 1'b1});
    vecs.push_back('{7'h7F, 1'b1, 7'h01, 1'b1, 1'b1, 8'hA6, 1'b1});
    vecs.push_back('{7'h00, 1'b1, 7'h00, 1'b1, 1'b1, 8'hA0, 1'b1});
    vecs.push_back('{7'h00, 1'b1, 7'h00, 1'b1, 1'b0, 8'h00, 1'b0});
    // Move ptr to 2, then sparse requests 5 and 2 back to back.
    vecs.push_back('{7'h04, 1'b1, 7'h04, 1'b1, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{7'h24, 1'b1, 7'h20, 1'b1, 1'b1, 8'hA2, 1'b1});
    vecs.push_back('{7'h24, 1'b1, 7'h04, 1'b1, 1'b1, 8'hA5, 1'b1});
    vecs.push_back('{7'h00, 1'b1, 7'h00, 1'b1, 1'b1, 8'hA2, 1'b1});
    vecs.push_back('{7'h00, 1'b1, 7'h00, 1'b1, 1'b0, 8'h00, 1'b0});
    // Backpressure: fill, hold grant on input 0, pop while full without push.
    vecs.push_back('{7'h03, 1'b0, 7'h01, 1'b1, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{7'h03, 1'b0, 7'h02, 1'b1, 1'b1, 8'hA0, 1'b1});
    vecs.push_back('{7'h03, 1'b0, 7'h01, 1'b0, 1'b1, 8'hA0, 1'b1});
    vecs.push_back('{7'h03, 1'b0, 7'h01, 1'b0, 1'b1, 8'hA0, 1'b1});
    vecs.push_back('{7'h03, 1'b1, 7'h01, 1'b0, 1'b1, 8'hA0, 1'b1});
    vecs.push_back('{7'h00, 1'b1, 7'h00, 1'b1, 1'b1, 8'hA1, 1'b1});
    vecs.push_back('{7'h00, 1'b1, 7'h00, 1'b1, 1'b0, 8'h00, 1'b0});

    // Reset with all inputs requesting.
    rst = 1'b1;
    applyStimulus(7'h7F, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rdy", 32'(obuf_rdy), 32'd1);
    checkOutput("rst_vld", 32'(obuf_vld), 32'd0);
    checkOutput("rst_gnt", 32'(arb_gnt), 32'h01);
    checkOutput("rst_cnt", 32'(pkt_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].link);
      @(negedge clk);
      checkOutput($sformatf("v%0d_gnt", i), 32'(arb_gnt), 32'(vecs[i].gnt));
      checkOutput($sformatf("v%0d_rdy", i), 32'(obuf_rdy), 32'(vecs[i].rdy));
      checkOutput($sformatf("v%0d_vld", i), 32'(obuf_vld), 32'(vecs[i].vld));
      if (vecs[i].chkp)
        checkOutput($sformatf("v%0d_pay", i), 32'(payload_o), 32'(vecs[i].pay));
      @(posedge clk);
      #1;
    end

`ifndef OBUF_STAT_EN
    checkOutput("nostat_cnt", 32'(pkt_cnt), 32'd0);
`endif

    // Mid-operation reset discards queued packets and restores ptr.
    applyStimulus(7'h03, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mid_full_rdy", 32'(obuf_rdy), 32'd0);
    checkOutput("mid_full_vld", 32'(obuf_vld), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(7'h7F, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_vld", 32'(obuf_vld), 32'd0);
    checkOutput("mid_rst_rdy", 32'(obuf_rdy), 32'd1);
    checkOutput("mid_rst_gnt", 32'(arb_gnt), 32'h01);
    applyStimulus(7'h00, 1'b1);

`ifdef OBUF_STAT_EN
    // Counter: small value, then saturation after 65540 pushes.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(7'h01, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("stat_3", 32'(pkt_cnt), 32'd3);
    repeat (65537) @(posedge clk);
    @(negedge clk);
    checkOutput("stat_sat", 32'(pkt_cnt), 32'hFFFF);
    applyStimulus(7'h00, 1'b1);
`else
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("nostat_end", 32'(pkt_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
